// File: rtl/key_tone_pkg.sv
// key_tone shared constants: note count, counter widths,
// half-period table (C4..C5 at 50 MHz) and FSM state type.
package key_tone_pkg;

  localparam int NOTE_NUM = 13;
  localparam int DIV_W    = 17;
  localparam int DUR_W    = 25;

  localparam logic [DIV_W-1:0] DIV_TAB [NOTE_NUM] = '{
    17'd95556, 17'd90193, 17'd85131, 17'd80353,
    17'd75843, 17'd71586, 17'd67568, 17'd63776,
    17'd60196, 17'd56818, 17'd53629, 17'd50619,
    17'd47778
  };

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  function automatic logic [DIV_W-1:0] div_of(
    input logic [3:0] idx
  );
    if (idx < 4'(NOTE_NUM)) return DIV_TAB[idx];
    else                    return DIV_TAB[0];
  endfunction

endpackage

// File: rtl/key_tone_prio.sv
// key_prio_enc: lowest set key wins.
// Outputs index of that key and a valid flag.
module key_prio_enc
  import key_tone_pkg::*;
(
  input  logic [NOTE_NUM-1:0] i_keys,
  output logic [3:0]          o_idx,
  output logic                o_vld
);

  always_comb begin
    o_idx = '0;
    o_vld = |i_keys;
    for (int i = NOTE_NUM - 1; i >= 0; i--) begin
      if (i_keys[i]) o_idx = 4'(i);
    end
  end

endmodule

// File: rtl/key_tone.sv
// key_tone: key pulse -> fixed-length square-wave note.
// KEY_TONE_RETRIG_EN lets a pulse restart a sounding note.
module key_tone
  import key_tone_pkg::*;
#(
  parameter int unsigned NOTE_LEN = 25_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NOTE_NUM-1:0] key_pulse,
  output logic                tone_out,
  output logic [3:0]          note_idx,
  output logic                playing
);

  state_t           r_state;
  state_t           w_nxt;
  logic             r_tone;
  logic [3:0]       r_note;
  logic [DIV_W-1:0] r_half;
  logic [DUR_W-1:0] r_dur;
  logic [3:0]       w_idx;
  logic             w_vld;
  logic             w_start;
  logic             w_expire;
  logic [DIV_W-1:0] w_lim;

  key_prio_enc u_enc (
    .i_keys (key_pulse),
    .o_idx  (w_idx),
    .o_vld  (w_vld)
  );

  assign w_lim    = div_of(r_note) - DIV_W'(1);
  assign w_expire = (r_state == PLAY) &&
                    (r_dur == DUR_W'(NOTE_LEN - 1));

  always_comb begin
    w_start = 1'b0;
    w_nxt   = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_vld) begin
          w_start = 1'b1;
          w_nxt   = PLAY;
        end
      end
      PLAY: begin
`ifdef KEY_TONE_RETRIG_EN
        if (w_vld) begin
          w_start = 1'b1;
          w_nxt   = PLAY;
        end else if (w_expire) begin
          w_nxt = IDLE;
        end
`else
        // pulses while sounding are ignored
        if (w_expire) w_nxt = IDLE;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tone  <= 1'b0;
      r_note  <= '0;
      r_half  <= '0;
      r_dur   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_start) begin
        r_note <= w_idx;
        r_tone <= 1'b0;
        r_half <= '0;
        r_dur  <= '0;
      end else if (w_nxt == IDLE) begin
        r_tone <= 1'b0;
        r_half <= '0;
        r_dur  <= '0;
      end else begin
        r_dur <= r_dur + DUR_W'(1);
        if (r_half == w_lim) begin
          r_half <= '0;
          r_tone <= ~r_tone;
        end else begin
          r_half <= r_half + DIV_W'(1);
        end
      end
    end
  end

  assign tone_out = r_tone;
  assign note_idx = r_note;
  assign playing  = (r_state == PLAY);

endmodule

// File: doc/key_tone.md
KEY_TONE -- requirements
Module: key_tone

Interface
REQ-001 clk  input  1  system clock, 50 MHz nominal.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 key_pulse  input  13  one-cycle debounced key-press pulses from the upstream key stage; bit k set = key k pressed.
REQ-004 tone_out  output  1  square-wave audio output.
REQ-005 note_idx  output  4  index (0..12) of the current or last accepted note.
REQ-006 playing  output  1  high while a note is sounding.
REQ-007 Parameter NOTE_LEN, default 25_000_000, is the note duration in clk cycles (range 2..2^25-1).

Function
REQ-008 Block SHALL have a two-state FSM: IDLE and PLAY.
REQ-009 key_pulse == 0 SHALL never change state.
REQ-010 Multiple bits set in one cycle SHALL select the lowest set index.
REQ-011 Accepted pulse in cycle T SHALL give, at T+1: playing=1, note_idx=k, tone_out=0, half-period and duration counters cleared.
REQ-012 In PLAY, tone_out SHALL toggle every DIV[note_idx] cycles; first toggle at T+1+DIV[k].
REQ-013 Duration counter SHALL count cycles in PLAY; after NOTE_LEN cycles in PLAY, FSM SHALL return to IDLE with playing=0 and tone_out=0.
REQ-014 In IDLE, tone_out SHALL be 0; note_idx SHALL hold its last value.
REQ-015 Half-period counter SHALL be 17 bits and SHALL wrap to 0 on each toggle. Duration counter SHALL be 25 bits.
REQ-016 DIV table (half-period counts at 50 MHz, C4..C5 chromatic) SHALL be: 95556, 90193, 85131, 80353, 75843, 71586, 67568, 63776, 60196, 56818, 53629, 50619, 47778.
REQ-017 Outputs SHALL be registered, with no combinational path from key_pulse to any output.

Reset
REQ-018 rst_n low SHALL immediately force: FSM=IDLE, tone_out=0, playing=0, note_idx=0, all counters 0.
REQ-019 Reset asserted mid-note SHALL abort the note. After release, only a new pulse SHALL start a note.

Configuration
REQ-020 Macro KEY_TONE_RETRIG_EN defined: a pulse in PLAY (including the expiry cycle) SHALL restart the note per REQ-011 with the new index.
REQ-021 Macro KEY_TONE_RETRIG_EN undefined: pulses SHALL be accepted only in IDLE. Pulses in PLAY, including the expiry cycle, SHALL be dropped.

Structure
REQ-022 Package key_tone_pkg SHALL hold NOTE_NUM=13, DIV_W=17, DUR_W=25, the DIV table constant, and the FSM state typedef.
REQ-023 Priority selection SHALL be a sub-module, key_prio_enc: 13-bit in, 4-bit index out, 1-bit valid out.

Verification
REQ-024 Reset, then key_pulse=13'h0001 for one cycle -> next cycle playing=1, note_idx=0; tone_out rises 95556 cycles later and falls 95556 cycles after that.
REQ-025 NOTE_LEN=1000, pulse 13'h1000 -> note_idx=12, playing high exactly 1000 cycles, then playing=0 and tone_out=0.
REQ-026 Pulse 13'h0014 (bits 2 and 4) -> note_idx=2, first toggle after 85131 cycles.
REQ-027 NOTE_LEN=1000, pulse bit 3, then pulse bit 7 at cycle 500 of the note -> with RETRIG_EN: note_idx=7, playing lasts to 1000 cycles after the second pulse; without: note_idx stays 3, ends at cycle 1000.
REQ-028 rst_n pulsed low mid-note -> tone_out=0, playing=0, note_idx=0 asynchronously; no output activity until the next pulse.
REQ-029 key_pulse=0 held for 10000 cycles from IDLE -> all outputs static.
